// File: rtl/arm_isa_pkg.sv
// Shared ARM subset definitions: op classes, ALU command codes and fixed encoding fields.
// Used by both the instruction decoder and the program-loader encoder.
package arm_isa_pkg;

    typedef enum logic [1:0] {
        CLS_DP  = 2'b00,
        CLS_MEM = 2'b01,
        CLS_BR  = 2'b10,
        CLS_ILL = 2'b11
    } op_cls_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_DONE = 2'b10
    } enc_state_e;

    localparam logic [3:0] COND_AL   = 4'hE;
    localparam logic [3:0] CMD_ADD   = 4'b0100;
    localparam logic [3:0] CMD_SUB   = 4'b0010;
    localparam logic [3:0] CMD_AND   = 4'b0000;
    localparam logic [3:0] CMD_ORR   = 4'b1100;
    // Bits [25:21] of a single-data-transfer word: I=0, P=1, U=1, B=0, W=0.
    localparam logic [4:0] MEM_FUNCT = 5'b01100;
    localparam logic [1:0] BR_OP     = 2'b10;

    function automatic logic [3:0] alu_cmd(input logic [1:0] op);
        logic [3:0] cmd;
        case (op)
            ALU_ADD: cmd = CMD_ADD;
            ALU_SUB: cmd = CMD_SUB;
            ALU_AND: cmd = CMD_AND;
            ALU_ORR: cmd = CMD_ORR;
            default: cmd = CMD_AND;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: field-level request -> 32-bit ARM word, plus an illegal-class flag.
module instr_field_packer
    import arm_isa_pkg::*;
(
    input  logic [1:0]  cls,
    input  logic [1:0]  aluop,
    input  logic        imm,
    input  logic        s,
    input  logic        load,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [23:0] src,
    output logic [31:0] word,
    output logic        illegal
);

    // Select the encoding layout from the op class.
    always_comb begin
        word    = 32'h0000_0000;
        illegal = 1'b0;
        case (cls)
            CLS_DP:  word = {COND_AL, 2'b00, imm, alu_cmd(aluop), s, rn, rd,
                             (imm ? {4'h0, src[7:0]} : {8'h00, src[3:0]})};
            CLS_MEM: word = {COND_AL, 2'b01, MEM_FUNCT, load, rn, rd, src[11:0]};
            CLS_BR:  word = {COND_AL, 2'b10, BR_OP, src[23:0]};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// Program loader: accepts field-level requests and writes encoded words sequentially
// into instruction memory, one registered write per legal request.
module instr_stream_encoder
    import arm_isa_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 32,
    parameter int          DEPTH     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        in_cls,
    input  logic [1:0]        in_aluop,
    input  logic              in_imm,
    input  logic              in_s,
    input  logic              in_load,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [23:0]       in_src,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [6:0]        count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [6:0] DEPTH_C = 7'(DEPTH);

    enc_state_e        state_r, next_state_s;
    logic [6:0]        count_r;
    logic [6:0]        slot_s;
    logic              err_r;
    logic              last_pend_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic [31:0]       word_s;
    logic              illegal_s;
    logic              accept_s;
    logic              write_s;
    logic              enter_load_s;

    instr_field_packer u_packer (
        .cls     (in_cls),
        .aluop   (in_aluop),
        .imm     (in_imm),
        .s       (in_s),
        .load    (in_load),
        .rn      (in_rn),
        .rd      (in_rd),
        .src     (in_src),
        .word    (word_s),
        .illegal (illegal_s)
    );

    // A write in flight (mem_we_r) already owns the next slot but is not yet counted.
    assign slot_s   = count_r + {6'd0, mem_we_r};
    assign in_ready = (state_r == ST_LOAD) && !last_pend_r && (slot_s < DEPTH_C);
    assign accept_s = in_valid && in_ready;
    assign write_s  = accept_s && !illegal_s;

    // Next-state logic; a legal last beat finishes once its write cycle has gone out.
    always_comb begin
        next_state_s = state_r;
        enter_load_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    next_state_s = ST_LOAD;
                    enter_load_s = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_LOAD: begin
                if ((accept_s && illegal_s && in_last) || last_pend_r || (count_r == DEPTH_C)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, counter, sticky error and registered write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            count_r     <= 7'd0;
            err_r       <= 1'b0;
            last_pend_r <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= ADDR_W'(BASE_ADDR);
            mem_wdata_r <= 32'h0000_0000;
        end else begin
            state_r  <= next_state_s;
            mem_we_r <= write_s;
            if (write_s) begin
                mem_addr_r  <= ADDR_W'(BASE_ADDR) + (ADDR_W'(slot_s) << 2);
                mem_wdata_r <= word_s;
            end
            if (enter_load_s) begin
                count_r     <= 7'd0;
                err_r       <= 1'b0;
                last_pend_r <= 1'b0;
            end else begin
                if (mem_we_r) begin
                    count_r <= count_r + 7'd1;
                end
                if (accept_s && illegal_s) begin
                    err_r <= 1'b1;
                end
                if (write_s && in_last) begin
                    last_pend_r <= 1'b1;
                end
            end
        end
    end

    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign count     = count_r;
    assign err       = err_r;
    assign busy      = (state_r == ST_LOAD);
    assign done      = (state_r == ST_DONE);

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Self-checking bench for instr_stream_encoder: directed and randomized load sessions
// compared against an arithmetic reference model of the encoding and write sequence.
module tb_instr_stream_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [1:0]  in_cls = 2'd0;
    logic [1:0]  in_aluop = 2'd0;
    logic        in_imm = 1'b0;
    logic        in_s = 1'b0;
    logic        in_load = 1'b0;
    logic [3:0]  in_rn = 4'd0;
    logic [3:0]  in_rd = 4'd0;
    logic [23:0] in_src = 24'd0;
    logic        in_ready, mem_we, busy, done, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [6:0]  count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_legal = 0;
    logic exp_err = 1'b0;
    logic [31:0] obs_addr_q[$], obs_data_q[$], exp_addr_q[$], exp_data_q[$];
    int obs_cyc_q[$];

    instr_stream_encoder dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_cls(in_cls), .in_aluop(in_aluop), .in_imm(in_imm), .in_s(in_s),
        .in_load(in_load), .in_rn(in_rn), .in_rd(in_rd), .in_src(in_src), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count), .busy(busy), .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset && mem_we) begin
            obs_addr_q.push_back(mem_addr);
            obs_data_q.push_back(mem_wdata);
            obs_cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encoding built from field weights rather than bit concatenation.
    function automatic logic [31:0] ref_word(input int cls, input int op, input int imm, input int s,
                                             input int ld, input int rn, input int rd, input int src);
        int cmd;
        longint w;
        cmd = (op == 0) ? 4 : (op == 1) ? 2 : (op == 2) ? 0 : 12;
        w = 64'hE000_0000;
        if (cls == 0) begin
            w += imm * (1 << 25) + cmd * (1 << 21) + s * (1 << 20) + rn * (1 << 16) + rd * (1 << 12);
            w += (imm != 0) ? (src % 256) : (src % 16);
        end else if (cls == 1) begin
            w += 1 * (1 << 26) + 12 * (1 << 21) + ld * (1 << 20) + rn * (1 << 16) + rd * (1 << 12);
            w += src % 4096;
        end else begin
            w += 10 * (1 << 24) + (src % (1 << 24));
        end
        return w[31:0];
    endfunction

    task automatic new_session();
        obs_addr_q.delete(); obs_data_q.delete(); obs_cyc_q.delete();
        exp_addr_q.delete(); exp_data_q.delete();
        n_legal = 0;
        exp_err = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", busy, 32'd1);
        check("start_count", count, 32'd0);
        check("start_err", err, 32'd0);
    endtask

    task automatic send(input int cls, input int op, input int imm, input int s, input int ld,
                        input int rn, input int rd, input int src, input logic last);
        int g;
        in_cls = 2'(cls); in_aluop = 2'(op); in_imm = 1'(imm); in_s = 1'(s); in_load = 1'(ld);
        in_rn = 4'(rn); in_rd = 4'(rd); in_src = 24'(src); in_last = last; in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (!in_ready) begin
            check("ready_timeout", in_ready, 32'd1);
            in_valid = 1'b0;
            in_last = 1'b0;
            return;
        end
        if (cls == 3) begin
            exp_err = 1'b1;
        end else begin
            exp_addr_q.push_back(32'(4 * n_legal));
            exp_data_q.push_back(ref_word(cls, op, imm, s, ld, rn, rd, src));
            n_legal++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_rand(input int max_cls, input logic last);
        send(int'($urandom_range(0, max_cls)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 24'hFF_FFFF)), last);
    endtask

    task automatic wait_done(input string tag);
        int g;
        g = 0;
        while (!done && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        check(tag, done, 32'd1);
    endtask

    task automatic check_session(input string tag);
        check({tag, "_count"}, count, 32'(n_legal));
        check({tag, "_err"}, err, exp_err);
        check({tag, "_nwrites"}, obs_data_q.size(), exp_data_q.size());
        for (int i = 0; i < exp_data_q.size() && i < obs_data_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), obs_addr_q[i], exp_addr_q[i]);
            check($sformatf("%s_data%0d", tag, i), obs_data_q[i], exp_data_q[i]);
        end
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", mem_we, 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_count", count, 32'd0);
        check("rst_err", err, 32'd0);
        check("rst_ready", in_ready, 32'd0);
        check("rst_done", done, 32'd0);
        check("rst_busy", busy, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // ADD immediate, single beat with last
        new_session();
        send(0, 0, 1, 0, 0, 1, 2, 24'h05, 1'b1);
        check("add_done_early", done, 32'd0);
        wait_done("add_done");
        check_session("add");
        check("add_const", obs_data_q[0], 32'hE281_2005);

        // SUB reg S, LDR, STR, branch
        new_session();
        send(0, 1, 0, 1, 0, 3, 4, 24'h5, 1'b0);
        send(1, 0, 0, 0, 1, 0, 1, 24'h00C, 1'b0);
        send(1, 0, 0, 0, 0, 0, 1, 24'h00C, 1'b0);
        send(2, 0, 0, 0, 0, 7, 9, 24'hFF_FFFE, 1'b1);
        wait_done("mix_done");
        check_session("mix");
        check("sub_const", obs_data_q[0], 32'hE053_4005);
        check("ldr_const", obs_data_q[1], 32'hE590_100C);
        check("str_const", obs_data_q[2], 32'hE580_100C);
        check("str_addr", obs_addr_q[2], 32'h8);
        check("br_const", obs_data_q[3], 32'hEAFF_FFFE);

        // Three back-to-back beats give three consecutive write cycles
        new_session();
        send_rand(2, 1'b0);
        send_rand(2, 1'b0);
        send_rand(2, 1'b1);
        wait_done("b2b_done");
        check_session("b2b");
        check("b2b_gap1", obs_cyc_q[1] - obs_cyc_q[0], 32'd1);
        check("b2b_gap2", obs_cyc_q[2] - obs_cyc_q[1], 32'd1);

        // Illegal mid-stream, with a start pulse in LOAD that must be ignored
        new_session();
        send_rand(2, 1'b0);
        start = 1'b1;
        send(3, 0, 0, 0, 0, 1, 1, 24'h1, 1'b0);
        start = 1'b0;
        send_rand(2, 1'b0);
        send_rand(2, 1'b1);
        wait_done("ill_done");
        check_session("ill");

        // Illegal beat carrying last enters DONE on the next cycle
        new_session();
        send_rand(2, 1'b0);
        send(3, 2, 1, 1, 1, 5, 6, 24'h77, 1'b1);
        check("ill_last_done", done, 32'd1);
        check_session("ill_last");

        // Randomized sessions
        for (int k = 0; k < 5; k++) begin
            int n;
            n = int'($urandom_range(4, 12));
            new_session();
            for (int j = 0; j < n; j++) begin
                send_rand(3, (j == n - 1));
            end
            wait_done($sformatf("rnd%0d_done", k));
            check_session($sformatf("rnd%0d", k));
        end

        // DEPTH beats without last saturate the session
        new_session();
        for (int j = 0; j < 64; j++) begin
            send_rand(2, 1'b0);
        end
        check("sat_ready", in_ready, 32'd0);
        wait_done("sat_done");
        check("sat_ready_done", in_ready, 32'd0);
        check_session("sat");
        check("sat_last_addr", obs_addr_q[63], 32'hFC);

        // Reset asserted while a write is on the port
        new_session();
        send_rand(2, 1'b0);
        check("mid_we", mem_we, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_we", mem_we, 32'd0);
        check("mid_rst_addr", mem_addr, 32'h0);
        check("mid_rst_wdata", mem_wdata, 32'h0);
        check("mid_rst_count", count, 32'd0);
        check("mid_rst_err", err, 32'd0);
        check("mid_rst_ready", in_ready, 32'd0);
        check("mid_rst_done", done, 32'd0);
        check("mid_rst_busy", busy, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
